// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the byte-sequencing memory controller: FSM states,
// data access sizes and the default IO region selector.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IF_RD = 2'd1,
    DC_RD = 2'd2,
    DC_WR = 2'd3
  } state_e;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  localparam logic [1:0] IO_SEL_DEFAULT = 2'b11;

  // Size code 3 is folded into a full word.
  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    case (sz)
      SZ_B:    size_bytes = 3'd1;
      SZ_H:    size_bytes = 3'd2;
      default: size_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Word-level memory controller: serialises one dcache or icache request into
// consecutive byte accesses on a byte-wide RAM port, dcache first.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter logic [1:0] IO_SEL = IO_SEL_DEFAULT
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_data,
  input  logic        flush_in,
  input  logic        dc_req,
  input  logic        dc_wr,
  input  logic [1:0]  dc_size,
  input  logic [31:0] dc_addr,
  input  logic [31:0] dc_wdata,
  output logic        dc_done,
  output logic [31:0] dc_rdata,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full,
  output logic [1:0]  dbg_state_o
);

  // Request side: a req is held until its done pulse; acceptance happens at an
  // edge in IDLE when req is high and that port's done is low. Done is a
  // single-cycle strobe with its data valid in the same cycle.

  state_e      state_q;
  logic [2:0]  cnt_q;
  logic [2:0]  n_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        io_q;
  logic [31:0] asm_q;
  logic        if_done_q;
  logic        dc_done_q;
  logic [31:0] if_data_q;
  logic [31:0] dc_rdata_q;
  logic [31:0] mem_a_q;
  logic [7:0]  mem_dout_q;
  logic        mem_wr_q;

  logic [2:0]  rd_next;
  logic [2:0]  wr_next;
  logic [1:0]  cap_idx;
  logic [31:0] asm_d;
  logic        rd_last;
  logic        wr_last;
  logic        dc_io_new;
  logic        wr_stall;

  // For reads, cnt is the number of edges since acceptance; the byte landing
  // on mem_din now was issued two edges ago, i.e. index cnt-1.
  always_comb begin
    rd_next   = cnt_q + 3'd1;
    wr_next   = mem_wr_q ? cnt_q + 3'd1 : cnt_q;
    cap_idx   = 2'(cnt_q - 3'd1);
    asm_d     = asm_q;
    asm_d[{cap_idx, 3'b000} +: 8] = mem_din;
    rd_last   = (cnt_q == n_q);
    wr_last   = (wr_next == n_q);
    dc_io_new = (dc_addr[17:16] == IO_SEL);
    wr_stall  = io_q & io_buffer_full;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q    <= IDLE;
      cnt_q      <= 3'd0;
      n_q        <= 3'd0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      io_q       <= 1'b0;
      asm_q      <= 32'd0;
      if_done_q  <= 1'b0;
      dc_done_q  <= 1'b0;
      if_data_q  <= 32'd0;
      dc_rdata_q <= 32'd0;
      mem_a_q    <= 32'd0;
      mem_dout_q <= 8'd0;
      mem_wr_q   <= 1'b0;
    end else if (rdy_in) begin
      if_done_q <= 1'b0;
      dc_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q      <= 3'd0;
          mem_wr_q   <= 1'b0;
          mem_a_q    <= 32'd0;
          mem_dout_q <= 8'd0;
          if (dc_req && !dc_done_q) begin
            addr_q  <= dc_addr;
            wdata_q <= dc_wdata;
            n_q     <= size_bytes(dc_size);
            io_q    <= dc_io_new;
            asm_q   <= 32'd0;
            mem_a_q <= dc_addr;
            if (dc_wr) begin
              state_q    <= DC_WR;
              mem_dout_q <= dc_wdata[7:0];
              mem_wr_q   <= !(dc_io_new && io_buffer_full);
            end else begin
              state_q <= DC_RD;
            end
          end else if (if_req && !if_done_q && !flush_in) begin
            addr_q  <= if_addr;
            n_q     <= 3'd4;
            io_q    <= 1'b0;
            asm_q   <= 32'd0;
            mem_a_q <= if_addr;
            state_q <= IF_RD;
          end
        end

        IF_RD, DC_RD: begin
          if (state_q == IF_RD && flush_in) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            mem_a_q <= 32'd0;
          end else if (rd_last) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            mem_a_q <= 32'd0;
            asm_q   <= asm_d;
            if (state_q == IF_RD) begin
              if_done_q <= 1'b1;
              if_data_q <= asm_d;
            end else begin
              dc_done_q  <= 1'b1;
              dc_rdata_q <= asm_d;
            end
          end else begin
            cnt_q <= rd_next;
            if (cnt_q != 3'd0) asm_q <= asm_d;
            if (rd_next < n_q) mem_a_q <= addr_q + {29'd0, rd_next};
          end
        end

        DC_WR: begin
          // A stalled cycle leaves mem_wr low, so the same byte is re-presented.
          if (wr_last) begin
            state_q    <= IDLE;
            cnt_q      <= 3'd0;
            mem_wr_q   <= 1'b0;
            mem_a_q    <= 32'd0;
            mem_dout_q <= 8'd0;
            dc_done_q  <= 1'b1;
          end else begin
            cnt_q      <= wr_next;
            mem_a_q    <= addr_q + {29'd0, wr_next};
            mem_dout_q <= wdata_q[{wr_next[1:0], 3'b000} +: 8];
            mem_wr_q   <= !wr_stall;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign if_done     = if_done_q;
  assign if_data     = if_data_q;
  assign dc_done     = dc_done_q;
  assign dc_rdata    = dc_rdata_q;
  assign mem_a       = mem_a_q;
  assign mem_dout    = mem_dout_q;
  // Gated so a frozen cycle never repeats a RAM write.
  assign mem_wr      = mem_wr_q & rdy_in;
  assign dbg_state_o = state_q;

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Word-level memory controller that sits between the requesters (dcache, icache) and the single byte-wide RAM port. It accepts one 1/2/4-byte data request or one 4-byte instruction fetch at a time and sequences it as consecutive byte accesses, giving dcache priority. It assembles read bytes little-endian and returns them with a one-cycle done pulse. It also stalls writes to the IO region while the IO buffer is full.

## Interface
Parameters:
- IO_SEL, 2'b11: value of addr[17:16] that marks the IO region.

Ports:
- clk_in  input  1  clock; all state updates on the rising edge.
- rst_in  input  1  asynchronous, active-low reset.
- rdy_in  input  1  global enable; low freezes all state.
- if_req  input  1  fetch request; held high until if_done.
- if_addr  input  32  fetch byte address.
- if_done  output  1  one-cycle pulse; if_data valid in the same cycle.
- if_data  output  32  fetched word.
- flush_in  input  1  abort any in-flight fetch (mispredict).
- dc_req  input  1  data request; held high until dc_done.
- dc_wr  input  1  1 = write, 0 = read.
- dc_size  input  2  0 = byte, 1 = half, 2 = word; 3 is illegal.
- dc_addr  input  32  data byte address.
- dc_wdata  input  32  write data; low bytes first.
- dc_done  output  1  one-cycle pulse.
- dc_rdata  output  32  read data, zero-extended; valid with dc_done.
- mem_din  input  8  RAM read byte; valid one cycle after the address is sampled.
- mem_dout  output  8  RAM write byte.
- mem_a  output  32  RAM byte address.
- mem_wr  output  1  1 = write; combinationally gated by rdy_in.
- io_buffer_full  input  1  IO sink cannot accept a byte.

## Operation
- States: IDLE, IF_RD, DC_RD, DC_WR. A 3-bit byte counter cnt tracks progress; byte count n = 1/2/4 from dc_size, and n = 4 for fetches.
- IDLE accepts a request at an edge only when the corresponding done output is low.
  - dc_req has priority over if_req.
  - dc_req with dc_wr = 1 → DC_WR; dc_req with dc_wr = 0 → DC_RD; if_req alone → IF_RD.
  - if_req with flush_in high at the same edge is not accepted.
- Address and data are latched at acceptance. Byte k uses mem_a = addr + k (wraps modulo 2^32) and, for writes, mem_dout = wdata[8k+7:8k].
- Reads:
  - Byte k is issued after edge k and captured from mem_din at edge k+2.
  - Byte j is placed at [8j+7:8j]; bytes at and above n are zero.
  - At the capture of byte n−1: done is set and the state returns to IDLE.
- Writes:
  - Byte k is driven with mem_wr = 1 for one cycle.
  - IO stall: if addr[17:16] == IO_SEL and io_buffer_full is sampled high at an edge, the next cycle drives mem_wr = 0 and cnt holds. The same byte retries until io_buffer_full is low.
  - After byte n−1: dc_done is pulsed, mem_wr = 0, and the state returns to IDLE.
- flush_in:
  - In IF_RD: the next edge → IDLE with no if_done; late bytes are discarded.
  - Ignored in DC_RD and DC_WR; data accesses are never aborted.
- Outside an access: mem_wr = 0, mem_a = 0, mem_dout = 0.
- dc_size = 3 is treated as 4 bytes. The bench must never drive it.

## Timing
- Reset (asynchronous, rst_in low): state = IDLE, cnt = 0. All outputs go to 0: if_done, dc_done, if_data, dc_rdata, mem_a, mem_dout, mem_wr.
- Reset mid-access abandons the access; no done is issued. A partial write stays in RAM.
- rdy_in low: no state, counter or output register changes, and mem_wr reads 0, so no byte is written twice.
- Accept at edge E0:
  - Read of n bytes: done high in the cycle after edge E(n+1). A word takes 5 cycles; a byte takes 2.
  - Write of n bytes: done high in the cycle after edge En, plus the number of IO stall cycles.
- Done is high for exactly one cycle. The earliest next acceptance is the edge that ends the done cycle; requesters must drop req by then.
- dc_rdata / if_data hold their value until the next done on that port.

## Structure
- Shared package: state encoding (IDLE, IF_RD, DC_RD, DC_WR), size encoding (SZ_B, SZ_H, SZ_W), and the IO_SEL default.
- Single module. The byte counter and assembly register are inline; no sub-module is warranted.

## Test plan
- Fetch: if_req with if_addr = 0x100 and RAM bytes 13 00 00 00 → if_data = 0x00000013, if_done in the cycle after edge E5, and mem_a sequence 0x100–0x103.
- Word store then load: dc_wr = 1, dc_size = 2, addr = 0x200, wdata = 0xDEADBEEF → RAM[0x200..0x203] = EF BE AD DE and dc_done after E4. A subsequent load of the same address returns 0xDEADBEEF.
- Byte load: RAM[0x301] = 0x80, dc_size = 0 → dc_rdata = 0x00000080 (zero-extended), dc_done after E2.
- Priority and flush:
  - dc_req and if_req in the same cycle → the data access completes first, then the fetch.
  - flush_in during IF_RD → no if_done, and the next request is accepted cleanly.
- IO stall: byte write to 0x30000 with io_buffer_full high for 3 cycles → mem_wr stays 0 for 3 cycles, then is high once, and dc_done follows.
- Reset mid-access: rst_in low during cnt = 2 of a word read → all outputs 0 immediately, no dc_done; a new request after release completes normally.
